syn_wm8731_codec_slave: RTL
===========================

Name: syn_wm8731_codec_slave

Overview:
Codec-side end of the WM8731 DSP-mode audio link. It behaves as the WM8731 would toward the audio-cortex driver: it consumes BCLK, DAC LRC and DAC data from the master, deserialises DAC frames into parallel PCM, and serialises ADC PCM onto adc_dat. It serves as a synthesizable loopback/codec stand-in for FPGA bring-up and for closed-loop verification of the audio cortex.

Parameters:
P_SYNC_STAGES, 2, synchroniser depth on bclk/lrc/dac_dat inputs (must satisfy P_SYNC_STAGES+1 < half BCLK period in clk_ir cycles).
P_PCM_W, 32, parallel PCM channel width.
P_BIT_IDX_W, 5, bit counter width (log2 of P_PCM_W).

Ports:
clk_ir  in  1  system clock; BCLK is oversampled on this clock.
rst_sync  in  1  synchronous, active-high reset.
cfg_en  in  1  1 = block active; 0 = forced to IDLE, adc_dat held 0.
cfg_bps  in  1  bps_t: BPS_32 (32 bits/channel) or BPS_16.
bclk  in  1  bit clock from master.
dac_lrc  in  1  DAC frame-sync pulse from master.
adc_lrc  in  1  ADC frame-sync pulse from master.
dac_dat  in  1  serial DAC data from master.
adc_dat  out  1  serial ADC data to master.
dac_pcm_valid  out  1  one-cycle pulse: dac_lpcm/dac_rpcm hold a new frame.
dac_lpcm  out  P_PCM_W  received left sample (sign-extended in BPS_16).
dac_rpcm  out  P_PCM_W  received right sample.
adc_pcm_valid  in  1  adc_lpcm/adc_rpcm hold a sample to transmit.
adc_lpcm  in  P_PCM_W  left sample to transmit.
adc_rpcm  in  P_PCM_W  right sample to transmit.
adc_pcm_ack  out  1  one-cycle pulse: ADC sample consumed.
frm_err  out  1  one-cycle pulse: LRC seen mid-frame.
adc_undrn  out  1  one-cycle pulse: frame started with adc_pcm_valid=0.

Behaviour:
- Reset/outputs: all outputs 0; FSM IDLE; shift registers and bit counter 0; synchroniser flops 0.
- Inputs bclk/dac_lrc/adc_lrc/dac_dat pass through P_SYNC_STAGES flops; a 1-cycle edge detector on synced bclk yields rise_c and fall_c.
- frame_sync_c = rise_c & (synced dac_lrc | synced adc_lrc).
- N = 32 (BPS_32) or 16 (BPS_16); cfg_bps is sampled at frame start and held for the frame.
- FSM states: IDLE, LCHANNEL, RCHANNEL.
  - IDLE -> LCHANNEL on frame_sync_c & cfg_en; bit_idx <= 0.
  - LCHANNEL: on each rise_c, shift synced dac_dat into the L shift register (MSB first) and increment bit_idx; on the rise where bit_idx == N-1, go to RCHANNEL and set bit_idx <= 0.
  - RCHANNEL: same, into the R shift register; on the rise where bit_idx == N-1, go to IDLE.
- dac_pcm_valid fires 1 cycle after the final R rise. dac_lpcm/dac_rpcm update in that same cycle and hold until the next frame. In BPS_16, bits [31:16] are the replica of bit 15.
- Frame start, ADC side:
  - If adc_pcm_valid=1: latch adc_lpcm/adc_rpcm into the ADC shift registers and pulse adc_pcm_ack in the same cycle.
  - If adc_pcm_valid=0: load zeros and pulse adc_undrn.
  - In BPS_16, transmit bits [15:0] only.
- adc_dat timing:
  - Updates only on fall_c.
  - In LCHANNEL it drives the L shifter MSB (bit 31 or bit 15), then shifts left; in RCHANNEL it does the same from the R shifter.
  - In IDLE it drives 0.
  - This yields exactly N bits per channel, with the first L bit valid before the first master sampling rise after the frame-sync rise.
  - Fall-to-adc_dat latency is P_SYNC_STAGES+1 cycles.
- frame_sync_c while in LCHANNEL/RCHANNEL: pulse frm_err, discard the partial frame (no dac_pcm_valid), restart in LCHANNEL with bit_idx=0, and reload the ADC shifters per the frame-start rule (resync).
- Final RCHANNEL rise coinciding with frame_sync_c is impossible, since LRC is sampled on a separate rise; no special handling.
- cfg_en deasserted mid-frame: next cycle go to IDLE, adc_dat=0, no dac_pcm_valid, no error pulse.
- rst_sync mid-frame: all state to reset values next edge; the partial frame is lost.
- bit_idx wraps naturally at 5 bits; it is compared against N-1, never relying on wrap in BPS_16.

Decomposition:
- syn_audio_pkg: reuse bps_t and the PCM struct (lchnnl/rchnnl); add the slave FSM enum and a constant for BPS_16 width (P_16B_W already in syn_global_pkg).
- One sub-module, syn_sync_edge_det: P_SYNC_STAGES synchroniser plus rise/fall detect, instantiated for bclk; the plain synchroniser path is used for the lrc/dat inputs.

Test Plan:
- BPS_32, BCLK = clk_ir/8, master sends L=0xA5A5_1234, R=0x8000_0001 -> one dac_pcm_valid pulse with exactly those values; frm_err=0.
- BPS_16, master sends L=0x8001, R=0x7FFE -> dac_lpcm=0xFFFF_8001, dac_rpcm=0x0000_7FFE.
- BPS_32, adc_pcm_valid=1 with L=0xDEAD_BEEF, R=0x0123_4567 -> adc_pcm_ack pulses once at frame start; master captures the identical values; back-to-back frames are also tested.
- adc_pcm_valid=0 at frame start -> adc_undrn pulse, adc_dat all-zero for the frame, no ack.
- LRC pulse injected after 10 L bits -> frm_err pulse, no dac_pcm_valid for the broken frame; the next full frame is received correctly.
- cfg_en dropped mid-RCHANNEL, and separately rst_sync mid-frame -> IDLE, adc_dat=0, no valid pulse; the following frame after re-enable is correct.

Source files
------------

// File: rtl/syn_wm8731_codec_slave_pkg.sv
// Shared types for the WM8731 codec-side DSP-mode link: word length select,
// stereo PCM pair and the slave frame FSM encoding.
package syn_wm8731_codec_slave_pkg;

   localparam int C_PCM_W = 32;
   localparam int P_16B_W = 16;

   typedef enum logic {
      BPS_32 = 1'b0,
      BPS_16 = 1'b1
   } bps_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LCHANNEL = 2'd1,
      ST_RCHANNEL = 2'd2
   } slv_state_t;

   typedef struct packed {
      logic [C_PCM_W-1:0] lchnnl;
      logic [C_PCM_W-1:0] rchnnl;
   } pcm_t;

   // Replicate bit 15 across the upper half of a received 16-bit sample.
   function automatic logic [C_PCM_W-1:0] sext16(input logic [C_PCM_W-1:0] v);
      return {{(C_PCM_W-P_16B_W){v[P_16B_W-1]}}, v[P_16B_W-1:0]};
   endfunction

endpackage

// File: rtl/syn_wm8731_codec_slave_if.sv
// Serial DSP-mode link between the audio-cortex master and the codec slave.
interface syn_wm8731_codec_slave_if;
   logic bclk;
   logic dac_lrc;
   logic adc_lrc;
   logic dac_dat;
   logic adc_dat;

   modport master (output bclk, output dac_lrc, output adc_lrc, output dac_dat, input adc_dat);
   modport slave  (input bclk, input dac_lrc, input adc_lrc, input dac_dat, output adc_dat);
endinterface

// File: rtl/syn_sync_edge_det.sv
// Multi-flop synchroniser with a one-cycle rise/fall detector on the synced
// output; used to turn the asynchronous BCLK into clk_ir-domain strobes.
module syn_sync_edge_det
   import syn_wm8731_codec_slave_pkg::*;
#(
   parameter int P_SYNC_STAGES = 2
) (
   input  logic clk_ir,
   input  logic rst_sync,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [P_SYNC_STAGES-1:0] sync_q, sync_d;
   logic                     prev_q, prev_d;

   generate
      for (genvar gi = 0; gi < P_SYNC_STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            assign sync_d[gi] = din;
         end else begin : g_next
            assign sync_d[gi] = sync_q[gi-1];
         end
      end
   endgenerate

   assign prev_d = sync_q[P_SYNC_STAGES-1];

   always_ff @(posedge clk_ir) begin
      if (rst_sync) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise = sync_q[P_SYNC_STAGES-1] & ~prev_q;
   assign fall = ~sync_q[P_SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/syn_wm8731_codec_slave.sv
// WM8731 stand-in: deserialises DAC frames from the master and serialises
// ADC samples back, all timed from an oversampled BCLK.
module syn_wm8731_codec_slave
   import syn_wm8731_codec_slave_pkg::*;
#(
   parameter int P_SYNC_STAGES = 2,
   parameter int P_PCM_W       = 32,
   parameter int P_BIT_IDX_W   = 5
) (
   input  logic                   clk_ir,
   input  logic                   rst_sync,
   input  logic                   cfg_en,
   input  bps_t                   cfg_bps,
   syn_wm8731_codec_slave_if.slave link,
   output logic                   dac_pcm_valid,
   output logic [P_PCM_W-1:0]     dac_lpcm,
   output logic [P_PCM_W-1:0]     dac_rpcm,
   input  logic                   adc_pcm_valid,
   input  logic [P_PCM_W-1:0]     adc_lpcm,
   input  logic [P_PCM_W-1:0]     adc_rpcm,
   output logic                   adc_pcm_ack,
   output logic                   frm_err,
   output logic                   adc_undrn
);

   localparam logic [P_BIT_IDX_W-1:0] C_LAST_32 = P_BIT_IDX_W'(P_PCM_W - 1);
   localparam logic [P_BIT_IDX_W-1:0] C_LAST_16 = P_BIT_IDX_W'(P_16B_W - 1);

   logic rise_c, fall_c;

   syn_sync_edge_det #(.P_SYNC_STAGES(P_SYNC_STAGES)) u_bclk_sync (
      .clk_ir   (clk_ir),
      .rst_sync (rst_sync),
      .din      (link.bclk),
      .rise     (rise_c),
      .fall     (fall_c)
   );

   // Same depth as the BCLK path so LRC/data line up with rise_c: [0]=dac_lrc [1]=adc_lrc [2]=dac_dat
   logic [P_SYNC_STAGES-1:0][2:0] in_sync_q, in_sync_d;

   generate
      for (genvar gi = 0; gi < P_SYNC_STAGES; gi++) begin : g_in_sync
         if (gi == 0) begin : g_first
            assign in_sync_d[gi] = {link.dac_dat, link.adc_lrc, link.dac_lrc};
         end else begin : g_next
            assign in_sync_d[gi] = in_sync_q[gi-1];
         end
      end
   endgenerate

   logic dac_lrc_s, adc_lrc_s, dac_dat_s, frame_sync_c;
   assign dac_lrc_s    = in_sync_q[P_SYNC_STAGES-1][0];
   assign adc_lrc_s    = in_sync_q[P_SYNC_STAGES-1][1];
   assign dac_dat_s    = in_sync_q[P_SYNC_STAGES-1][2];
   assign frame_sync_c = rise_c & (dac_lrc_s | adc_lrc_s);

   slv_state_t               state_q, state_d;
   logic [P_BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
   bps_t                     bps_q, bps_d;
   logic [P_PCM_W-1:0]       dac_l_sr_q, dac_l_sr_d;
   logic [P_PCM_W-1:0]       dac_r_sr_q, dac_r_sr_d;
   pcm_t                     adc_sr_q, adc_sr_d;
   pcm_t                     dac_pcm_q, dac_pcm_d;
   logic                     adc_dat_q, adc_dat_d;
   logic                     dac_pcm_valid_q, dac_pcm_valid_d;
   logic                     adc_pcm_ack_q, adc_pcm_ack_d;
   logic                     frm_err_q, frm_err_d;
   logic                     adc_undrn_q, adc_undrn_d;

   logic [P_BIT_IDX_W-1:0]   last_idx_c;
   logic [P_PCM_W-1:0]       dac_l_shift_c, dac_r_shift_c;
   logic                     adc_msb_l_c, adc_msb_r_c;

   assign last_idx_c    = (bps_q == BPS_16) ? C_LAST_16 : C_LAST_32;
   assign dac_l_shift_c = {dac_l_sr_q[P_PCM_W-2:0], dac_dat_s};
   assign dac_r_shift_c = {dac_r_sr_q[P_PCM_W-2:0], dac_dat_s};
   assign adc_msb_l_c   = (bps_q == BPS_16) ? adc_sr_q.lchnnl[P_16B_W-1] : adc_sr_q.lchnnl[P_PCM_W-1];
   assign adc_msb_r_c   = (bps_q == BPS_16) ? adc_sr_q.rchnnl[P_16B_W-1] : adc_sr_q.rchnnl[P_PCM_W-1];

   always_comb begin
      state_d         = state_q;
      bit_idx_d       = bit_idx_q;
      bps_d           = bps_q;
      dac_l_sr_d      = dac_l_sr_q;
      dac_r_sr_d      = dac_r_sr_q;
      adc_sr_d        = adc_sr_q;
      dac_pcm_d       = dac_pcm_q;
      adc_dat_d       = adc_dat_q;
      dac_pcm_valid_d = 1'b0;
      adc_pcm_ack_d   = 1'b0;
      frm_err_d       = 1'b0;
      adc_undrn_d     = 1'b0;

      if (!cfg_en) begin
         state_d   = ST_IDLE;
         bit_idx_d = '0;
         adc_dat_d = 1'b0;
      end else if (frame_sync_c) begin
         // A sync mid-frame drops the partial frame and restarts cleanly.
         frm_err_d       = (state_q != ST_IDLE);
         state_d         = ST_LCHANNEL;
         bit_idx_d       = '0;
         bps_d           = cfg_bps;
         adc_pcm_ack_d   = adc_pcm_valid;
         adc_undrn_d     = ~adc_pcm_valid;
         adc_sr_d.lchnnl = adc_pcm_valid ? adc_lpcm : '0;
         adc_sr_d.rchnnl = adc_pcm_valid ? adc_rpcm : '0;
      end else if (rise_c) begin
         case (state_q)
            ST_LCHANNEL: begin
               dac_l_sr_d = dac_l_shift_c;
               bit_idx_d  = bit_idx_q + P_BIT_IDX_W'(1);
               if (bit_idx_q == last_idx_c) begin
                  state_d   = ST_RCHANNEL;
                  bit_idx_d = '0;
               end
            end
            ST_RCHANNEL: begin
               dac_r_sr_d = dac_r_shift_c;
               bit_idx_d  = bit_idx_q + P_BIT_IDX_W'(1);
               if (bit_idx_q == last_idx_c) begin
                  state_d          = ST_IDLE;
                  bit_idx_d        = '0;
                  dac_pcm_valid_d  = 1'b1;
                  dac_pcm_d.lchnnl = (bps_q == BPS_16) ? sext16(dac_l_sr_q) : dac_l_sr_q;
                  dac_pcm_d.rchnnl = (bps_q == BPS_16) ? sext16(dac_r_shift_c) : dac_r_shift_c;
               end
            end
            default: ;
         endcase
      end else if (fall_c) begin
         case (state_q)
            ST_LCHANNEL: begin
               adc_dat_d       = adc_msb_l_c;
               adc_sr_d.lchnnl = {adc_sr_q.lchnnl[P_PCM_W-2:0], 1'b0};
            end
            ST_RCHANNEL: begin
               adc_dat_d       = adc_msb_r_c;
               adc_sr_d.rchnnl = {adc_sr_q.rchnnl[P_PCM_W-2:0], 1'b0};
            end
            default: adc_dat_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk_ir) begin
      if (rst_sync) begin
         in_sync_q       <= '0;
         state_q         <= ST_IDLE;
         bit_idx_q       <= '0;
         bps_q           <= BPS_32;
         dac_l_sr_q      <= '0;
         dac_r_sr_q      <= '0;
         adc_sr_q        <= '0;
         dac_pcm_q       <= '0;
         adc_dat_q       <= 1'b0;
         dac_pcm_valid_q <= 1'b0;
         adc_pcm_ack_q   <= 1'b0;
         frm_err_q       <= 1'b0;
         adc_undrn_q     <= 1'b0;
      end else begin
         in_sync_q       <= in_sync_d;
         state_q         <= state_d;
         bit_idx_q       <= bit_idx_d;
         bps_q           <= bps_d;
         dac_l_sr_q      <= dac_l_sr_d;
         dac_r_sr_q      <= dac_r_sr_d;
         adc_sr_q        <= adc_sr_d;
         dac_pcm_q       <= dac_pcm_d;
         adc_dat_q       <= adc_dat_d;
         dac_pcm_valid_q <= dac_pcm_valid_d;
         adc_pcm_ack_q   <= adc_pcm_ack_d;
         frm_err_q       <= frm_err_d;
         adc_undrn_q     <= adc_undrn_d;
      end
   end

   assign link.adc_dat  = adc_dat_q;
   assign dac_pcm_valid = dac_pcm_valid_q;
   assign dac_lpcm      = dac_pcm_q.lchnnl;
   assign dac_rpcm      = dac_pcm_q.rchnnl;
   assign adc_pcm_ack   = adc_pcm_ack_q;
   assign frm_err       = frm_err_q;
   assign adc_undrn     = adc_undrn_q;

endmodule
